dual_xor_cipher_core: RTL and testbench
=======================================

Name: dual_xor_cipher_core

Overview:
- Device-under-test stage directly downstream of the dual-XOR test stimulus block.
- Receives the serial configuration word (taps, seeds, mux bits) over a cfg_en/cfg_i shift chain and loads it into a TX and an RX Galois LFSR.
- While enabled, encrypts the plaintext stream with the TX keystream and decrypts it with the RX keystream.
- Returns the decrypted bit to the stimulus block for error counting, and passes the chain through on cfg_o for daisy-chaining.

Parameters:
- M, 32: LFSR width in bits. Configuration word length is W = 4*M+2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_en  in  1  shift enable for the configuration chain
- cfg_i  in  1  serial configuration input; LSB of the word arrives first
- cfg_o  out  1  serial chain output, equal to shadow[0]
- en  in  1  run enable; each high cycle advances both LFSRs by one step
- data_i  in  1  plaintext bit
- cipher_i  in  1  external ciphertext bit, used when ext_a=0
- cipher_o  out  1  ciphertext = data_i ^ k_tx
- decrypted  out  1  recovered plaintext
- cfg_valid  out  1  a complete word has been loaded since reset
- cfg_err  out  1  sticky: the last shift burst length was not W
- state_o  out  2  FSM state, for debug

Behaviour:
- Reset (rst_n=0, asynchronous): clears shadow, both LFSRs, bit counter, cfg_valid and cfg_err; state=IDLE.
- Shift register: shadow[W-1:0]. When cfg_en=1: shadow <= {cfg_i, shadow[W-1:1]}.
- Word layout, MSB to LSB: {ext_a, byp_d, tx_taps[M], tx_seed[M], rx_taps[M], rx_seed[M]}.
- Bit counter: 11 bits, counts cfg_en-high cycles and saturates at 2047.
- FSM states: IDLE=0, SHIFT=1, ARMED=2, RUN=3.
  - Any state → SHIFT when cfg_en=1; the bit counter is cleared on entry.
  - SHIFT, cfg_en falls with count==W: load the operating registers (below); clear cfg_err; set cfg_valid; → ARMED.
  - SHIFT, cfg_en falls with count!=W: no load; set cfg_err; operating registers unchanged; → ARMED if cfg_valid, else IDLE.
  - ARMED → RUN when en=1 and cfg_en=0.
  - RUN → ARMED when en=0.
  - IDLE ignores en.
- Load on cfg_en falling edge: tx_lfsr<=tx_seed, rx_lfsr<=rx_seed, taps latched, ext_a/byp_d latched.
- LFSR step (only in RUN with en=1), for each LFSR:
  - k = lfsr[0]
  - lfsr <= (lfsr >> 1) ^ (k ? taps : 0)
- Keystream: k_tx = tx_lfsr[0], k_rx = rx_lfsr[0]. Both are registered, so the datapath is combinational with zero-cycle latency from data_i.
- Outputs:
  - cipher_o = data_i ^ k_tx
  - a = ext_a ? cipher_o : cipher_i
  - decrypted = byp_d ? a : (a ^ k_rx)
- Outputs outside RUN: k_tx and k_rx are forced to 0, so cipher_o=data_i and decrypted=a.
- cfg_en and en both high: cfg_en wins; the LFSRs hold; a keystream step never coincides with a load.
- All-zero seed: the LFSR stays 0 (lock-up state); this is legal and not flagged.
- Reset mid-shift or mid-run: immediate return to IDLE; cfg_valid=0.

Decomposition:
- Shared package: W, state encodings (IDLE/SHIFT/ARMED/RUN), bit positions EXT_A=W-1 and BYP_D=W-2, and field offsets.
- Sub-module: galois_lfsr with parameter N=M and ports clk, rst_n, en, ld, taps, lfsr_i, lfsr_o, k, instantiated twice (TX and RX).
- FSM, shadow register and counter stay in the top module.

Test Plan (M=32):
1. Round trip: shift W=130 bits with ext_a=1, byp_d=0, tx=rx taps 0x80200003, seeds 0x1; en for 900 cycles with PRBS-7 data_i -> decrypted==data_i every cycle; cfg_valid=1; cfg_err=0; state RUN.
2. Seed mismatch: tx_seed=0x1, rx_seed=0x2, otherwise as scenario 1 -> decrypted!=data_i within the first 32 en cycles; cipher_o differs from data_i.
3. Short burst: after a good load, cfg_en high for 10 cycles -> cfg_err=1; state ARMED; LFSRs unchanged; a subsequent run still decrypts correctly.
4. Chain pass-through: shift 260 bits -> cfg_o sequence equals cfg_i delayed by exactly 130 cycles.
5. Priority and reset: cfg_en=en=1 -> no LFSR step; rst_n low during the 40th RUN cycle -> cfg_valid=0 and state IDLE immediately, without waiting for a clock edge.
6. Bypass and external input: byp_d=1, ext_a=0, cipher_i toggling -> decrypted==cipher_i every cycle.

Source files
------------

// File: rtl/dual_xor_cipher_core_pkg.sv
// Shared definitions for the dual-XOR cipher core: configuration word geometry,
// field offsets and FSM state encodings.
package dual_xor_cipher_core_pkg;

    localparam int M_DEF = 32;
    localparam int W     = 4 * M_DEF + 2;
    localparam int EXT_A = W - 1;
    localparam int BYP_D = W - 2;

    localparam int CNT_W = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ARMED = 2'd2,
        RUN   = 2'd3
    } state_t;

    // Word layout, MSB to LSB: {ext_a, byp_d, tx_taps, tx_seed, rx_taps, rx_seed}
    function automatic int cfg_width(input int m);
        return 4 * m + 2;
    endfunction

    function automatic int rx_seed_off(input int m);
        return 0 * m;
    endfunction

    function automatic int rx_taps_off(input int m);
        return 1 * m;
    endfunction

    function automatic int tx_seed_off(input int m);
        return 2 * m;
    endfunction

    function automatic int tx_taps_off(input int m);
        return 3 * m;
    endfunction

    function automatic int byp_d_pos(input int m);
        return 4 * m;
    endfunction

    function automatic int ext_a_pos(input int m);
        return 4 * m + 1;
    endfunction

endpackage

// File: rtl/dual_xor_cipher_core_galois_lfsr.sv
// Galois LFSR with loadable seed and taps; k is the registered output bit that
// feeds back into the tapped positions on each step.
module galois_lfsr #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         ld,
    input  logic [N-1:0] taps,
    input  logic [N-1:0] lfsr_i,
    output logic [N-1:0] lfsr_o,
    output logic         k
);

    logic [N-1:0] lfsr_reg;
    logic [N-1:0] taps_reg;
    logic [N-1:0] lfsr_next;

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        if (gi == N - 1) begin : g_top
            assign lfsr_next[gi] = taps_reg[gi] & lfsr_reg[0];
        end else begin : g_mid
            assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (taps_reg[gi] & lfsr_reg[0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= '0;
            taps_reg <= '0;
        end else if (ld) begin
            lfsr_reg <= lfsr_i;
            taps_reg <= taps;
        end else if (en) begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign lfsr_o = lfsr_reg;
    assign k      = lfsr_reg[0];

endmodule

// File: rtl/dual_xor_cipher_core.sv
// Serially configured TX/RX keystream cipher: encrypts data_i with the TX LFSR,
// decrypts the selected ciphertext with the RX LFSR, and daisy-chains the config.
module dual_xor_cipher_core
    import dual_xor_cipher_core_pkg::*;
#(
    parameter int M = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_en,
    input  logic       cfg_i,
    output logic       cfg_o,
    input  logic       en,
    input  logic       data_i,
    input  logic       cipher_i,
    output logic       cipher_o,
    output logic       decrypted,
    output logic       cfg_valid,
    output logic       cfg_err,
    output logic [1:0] state_o
);

    localparam int                 W_CFG = cfg_width(M);
    localparam logic [CNT_W-1:0]   W_CNT = CNT_W'(W_CFG);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    logic [W_CFG-1:0] shadow_reg;
    logic [CNT_W-1:0] cnt_reg;
    state_t           state_reg;
    state_t           state_next;
    logic             cfg_valid_reg;
    logic             cfg_err_reg;
    logic             ext_a_reg;
    logic             byp_d_reg;

    logic             load;
    logic             bad_end;
    logic             step;
    logic             run;
    logic             tx_k;
    logic             rx_k;
    logic             k_tx;
    logic             k_rx;
    logic             a;
    logic [M-1:0]     tx_lfsr;
    logic [M-1:0]     rx_lfsr;

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        bad_end    = 1'b0;
        if (cfg_en) begin
            state_next = SHIFT;
        end else begin
            unique case (state_reg)
                SHIFT: begin
                    if (cnt_reg == W_CNT) begin
                        load       = 1'b1;
                        state_next = ARMED;
                    end else begin
                        bad_end    = 1'b1;
                        state_next = cfg_valid_reg ? ARMED : IDLE;
                    end
                end
                ARMED: if (en) state_next = RUN;
                RUN:   if (!en) state_next = ARMED;
                default: state_next = state_reg;
            endcase
        end
    end

    // cfg_en has priority, so a keystream step can never coincide with a load.
    assign step = (state_reg == RUN) && en && !cfg_en;
    assign run  = (state_reg == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shadow_reg    <= '0;
            cnt_reg       <= '0;
            cfg_valid_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
            ext_a_reg     <= 1'b0;
            byp_d_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (cfg_en) begin
                shadow_reg <= {cfg_i, shadow_reg[W_CFG-1:1]};
                // The entry cycle already carries one bit, hence restart at 1.
                if (state_reg != SHIFT) begin
                    cnt_reg <= CNT_W'(1);
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            if (load) begin
                cfg_valid_reg <= 1'b1;
                cfg_err_reg   <= 1'b0;
                ext_a_reg     <= shadow_reg[ext_a_pos(M)];
                byp_d_reg     <= shadow_reg[byp_d_pos(M)];
            end else if (bad_end) begin
                cfg_err_reg   <= 1'b1;
            end
        end
    end

    galois_lfsr #(
        .N(M)
    ) u_tx_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (step),
        .ld     (load),
        .taps   (shadow_reg[tx_taps_off(M) +: M]),
        .lfsr_i (shadow_reg[tx_seed_off(M) +: M]),
        .lfsr_o (tx_lfsr),
        .k      (tx_k)
    );

    galois_lfsr #(
        .N(M)
    ) u_rx_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (step),
        .ld     (load),
        .taps   (shadow_reg[rx_taps_off(M) +: M]),
        .lfsr_i (shadow_reg[rx_seed_off(M) +: M]),
        .lfsr_o (rx_lfsr),
        .k      (rx_k)
    );

    // Keystream is suppressed outside RUN so the datapath degrades to a passthrough.
    assign k_tx      = run & tx_k;
    assign k_rx      = run & rx_k;
    assign cipher_o  = data_i ^ k_tx;
    assign a         = ext_a_reg ? cipher_o : cipher_i;
    assign decrypted = byp_d_reg ? a : (a ^ k_rx);

    assign cfg_o     = shadow_reg[0];
    assign cfg_valid = cfg_valid_reg;
    assign cfg_err   = cfg_err_reg;
    assign state_o   = state_reg;

    // An all-zero LFSR is a lock-up state: stepping must keep it at zero.
    lockup_tx: assert property (@(posedge clk) disable iff (!rst_n)
        (!load && tx_lfsr == '0) |=> (tx_lfsr == '0));
    lockup_rx: assert property (@(posedge clk) disable iff (!rst_n)
        (!load && rx_lfsr == '0) |=> (rx_lfsr == '0));

endmodule

// File: tb/tb_dual_xor_cipher_core.sv
// Directed bench for dual_xor_cipher_core: table of hand-computed keystream
// vectors plus sequences for chain delay, short bursts, priority and reset.
module tb_dual_xor_cipher_core;

    localparam int M = 32;
    localparam int W = 4 * M + 2;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_en = 1'b0;
    logic       cfg_i = 1'b0;
    logic       en = 1'b0;
    logic       data_i = 1'b0;
    logic       cipher_i = 1'b0;
    logic       cfg_o;
    logic       cipher_o;
    logic       decrypted;
    logic       cfg_valid;
    logic       cfg_err;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    // Bench-side keystream model
    logic [31:0] m_tx, m_rx, m_txt, m_rxt;
    logic        m_ext, m_byp;
    logic        exp_run;
    logic [6:0]  prbs = 7'h7F;

    typedef struct packed {
        logic       d;
        logic       ci;
        logic       exp_c;
        logic       exp_dec;
        logic [1:0] exp_st;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    dual_xor_cipher_core #(.M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .cfg_i     (cfg_i),
        .cfg_o     (cfg_o),
        .en        (en),
        .data_i    (data_i),
        .cipher_i  (cipher_i),
        .cipher_o  (cipher_o),
        .decrypted (decrypted),
        .cfg_valid (cfg_valid),
        .cfg_err   (cfg_err),
        .state_o   (state_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] t);
        return (s >> 1) ^ (s[0] ? t : 32'h0);
    endfunction

    function automatic logic [W-1:0] mk_word(input logic ea, input logic bd,
                                             input logic [31:0] tt, input logic [31:0] ts,
                                             input logic [31:0] rt, input logic [31:0] rs);
        return {ea, bd, tt, ts, rt, rs};
    endfunction

    task automatic shift_word(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            cfg_en = 1'b1;
            cfg_i  = (i < W) ? w[i] : 1'b0;
            tick();
        end
        cfg_en = 1'b0;
        tick();
    endtask

    task automatic load(input logic ea, input logic bd, input logic [31:0] ts, input logic [31:0] rs);
        shift_word(mk_word(ea, bd, TAPS, ts, TAPS, rs), W);
        m_tx = ts; m_rx = rs; m_txt = TAPS; m_rxt = TAPS;
        m_ext = ea; m_byp = bd; exp_run = 1'b0;
        $display("load ext_a=%0b byp_d=%0b tx_seed=%08h rx_seed=%08h", ea, bd, ts, rs);
    endtask

    task automatic run_cycles(input int n, input bit toggle_ci, input string tag);
        logic ktx, krx, ec, ea, ed;
        for (int c = 0; c < n; c++) begin
            en       = 1'b1;
            data_i   = prbs[6] ^ prbs[5];
            prbs     = {prbs[5:0], prbs[6] ^ prbs[5]};
            cipher_i = toggle_ci ? c[0] : 1'($urandom_range(0, 1));
            #2;
            ktx = exp_run ? m_tx[0] : 1'b0;
            krx = exp_run ? m_rx[0] : 1'b0;
            ec  = data_i ^ ktx;
            ea  = m_ext ? ec : cipher_i;
            ed  = m_byp ? ea : (ea ^ krx);
            check({tag, "_cipher"}, 32'(cipher_o), 32'(ec));
            check({tag, "_dec"}, 32'(decrypted), 32'(ed));
            @(posedge clk);
            if (exp_run) begin
                m_tx = lfsr_step(m_tx, m_txt);
                m_rx = lfsr_step(m_rx, m_rxt);
            end
            exp_run = 1'b1;
            #1;
        end
        en = 1'b0;
        $display("run %s: %0d cycles", tag, n);
    endtask

    initial begin
        logic [259:0] chain;
        // seed1/seed2 keystreams: tx 1,1,0,1,1,0  rx 0,1,1,0,1,1
        tbl[0] = '{d:1'b1, ci:1'b0, exp_c:1'b1, exp_dec:1'b1, exp_st:S_ARMED};
        tbl[1] = '{d:1'b1, ci:1'b0, exp_c:1'b0, exp_dec:1'b0, exp_st:S_RUN};
        tbl[2] = '{d:1'b0, ci:1'b1, exp_c:1'b1, exp_dec:1'b0, exp_st:S_RUN};
        tbl[3] = '{d:1'b1, ci:1'b1, exp_c:1'b1, exp_dec:1'b0, exp_st:S_RUN};
        tbl[4] = '{d:1'b1, ci:1'b0, exp_c:1'b0, exp_dec:1'b0, exp_st:S_RUN};
        tbl[5] = '{d:1'b0, ci:1'b1, exp_c:1'b1, exp_dec:1'b0, exp_st:S_RUN};
        tbl[6] = '{d:1'b0, ci:1'b0, exp_c:1'b0, exp_dec:1'b1, exp_st:S_RUN};

        // Reset state
        #3;
        check("rst_state", 32'(state_o), 32'(S_IDLE));
        check("rst_valid", 32'(cfg_valid), 32'h0);
        check("rst_err", 32'(cfg_err), 32'h0);
        check("rst_cfg_o", 32'(cfg_o), 32'h0);
        check("rst_cipher", 32'(cipher_o), 32'h0);
        tick();
        rst_n = 1'b1;

        // IDLE ignores en; datapath is a passthrough
        en = 1'b1; data_i = 1'b1; cipher_i = 1'b1;
        tick(); tick();
        check("idle_state", 32'(state_o), 32'(S_IDLE));
        check("idle_cipher", 32'(cipher_o), 32'h1);
        check("idle_dec", 32'(decrypted), 32'h1);
        en = 1'b0;
        $display("idle with en held: state=%0d", state_o);

        // Chain pass-through, 260-bit burst from unconfigured state
        for (int i = 0; i < 260; i++) chain[i] = 1'($urandom_range(0, 1));
        for (int j = 0; j < 260; j++) begin
            cfg_en = 1'b1;
            cfg_i  = chain[j];
            #2;
            if (j >= W) check("chain_cfg_o", 32'(cfg_o), 32'(chain[j-W]));
            tick();
        end
        cfg_en = 1'b0;
        tick();
        check("chain_err", 32'(cfg_err), 32'h1);
        check("chain_state", 32'(state_o), 32'(S_IDLE));
        check("chain_valid", 32'(cfg_valid), 32'h0);
        $display("chain 260 bits: cfg_err=%0b state=%0d", cfg_err, state_o);

        // Round trip
        load(1'b1, 1'b0, 32'h1, 32'h1);
        check("rt_load_state", 32'(state_o), 32'(S_ARMED));
        check("rt_load_err", 32'(cfg_err), 32'h0);
        check("rt_load_valid", 32'(cfg_valid), 32'h1);
        run_cycles(900, 1'b0, "rt");
        check("rt_state", 32'(state_o), 32'(S_RUN));
        check("rt_valid", 32'(cfg_valid), 32'h1);
        check("rt_err", 32'(cfg_err), 32'h0);

        // Short burst with en held high: cfg_en wins, LFSRs hold
        for (int i = 0; i < 10; i++) begin
            cfg_en = 1'b1; en = 1'b1; cfg_i = 1'($urandom_range(0, 1));
            tick();
        end
        cfg_en = 1'b0; en = 1'b0;
        tick();
        check("short_err", 32'(cfg_err), 32'h1);
        check("short_state", 32'(state_o), 32'(S_ARMED));
        check("short_valid", 32'(cfg_valid), 32'h1);
        $display("short burst 10 bits: cfg_err=%0b state=%0d", cfg_err, state_o);
        exp_run = 1'b0;
        run_cycles(100, 1'b0, "after_short");
        check("after_short_err", 32'(cfg_err), 32'h1);

        // Seed mismatch, hand-computed vectors
        load(1'b1, 1'b0, 32'h1, 32'h2);
        check("mm_err_cleared", 32'(cfg_err), 32'h0);
        for (int v = 0; v < 7; v++) begin
            en = 1'b1; data_i = tbl[v].d; cipher_i = tbl[v].ci;
            #2;
            check($sformatf("vec%0d_state", v), 32'(state_o), 32'(tbl[v].exp_st));
            check($sformatf("vec%0d_cipher", v), 32'(cipher_o), 32'(tbl[v].exp_c));
            check($sformatf("vec%0d_dec", v), 32'(decrypted), 32'(tbl[v].exp_dec));
            $display("vec %0d: d=%0b cipher_o=%0b decrypted=%0b", v, data_i, cipher_o, decrypted);
            tick();
        end
        en = 1'b0;

        // Reset during the 40th RUN cycle
        load(1'b1, 1'b0, 32'h1, 32'h1);
        run_cycles(40, 1'b0, "pre_rst");
        en = 1'b1;
        #1;
        check("pre_rst_state", 32'(state_o), 32'(S_RUN));
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state_o), 32'(S_IDLE));
        check("async_rst_valid", 32'(cfg_valid), 32'h0);
        check("async_rst_cipher", 32'(cipher_o), 32'(data_i));
        $display("async reset mid-run: state=%0d cfg_valid=%0b", state_o, cfg_valid);
        tick();
        rst_n = 1'b1; en = 1'b0;

        // Bypass with external ciphertext
        load(1'b0, 1'b1, 32'h1, 32'h1);
        check("byp_valid", 32'(cfg_valid), 32'h1);
        run_cycles(50, 1'b1, "bypass");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: actual still running required finished");
        $fatal(1, "timeout");
    end

endmodule
